// File: rtl/up_down_counter_mod.sv
// Up/down counter with programmable modulo bound and step, count enable,
// wrap-or-saturate behaviour, a registered terminal-event pulse and at-limit flags.
module up_down_counter_mod #(
    parameter int N      = 8,
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              up_down,
    input  logic              load,
    input  logic [N-1:0]      input_load,
    input  logic [N-1:0]      modulo_max,
    input  logic [STEP_W-1:0] step,
    input  logic              sat_mode,
    output logic [N-1:0]      count_out,
    output logic              carry_out,
    output logic              at_max,
    output logic              at_min
);

    logic [N-1:0] count_q, count_d;
    logic         carry_q, carry_d;

    // All arithmetic is carried at N+1 bits so modulo_max == 2^N-1 is exact.
    logic [N:0] max_ext;
    logic [N:0] range_ext;
    logic [N:0] step_ext;
    logic [N:0] step_eff;
    logic [N:0] cnt_ext;
    logic [N:0] sum_up;
    logic [N:0] wrap_up;
    logic [N:0] diff_dn;
    logic [N:0] wrap_dn;

    always_comb begin
        max_ext   = {1'b0, modulo_max};
        range_ext = max_ext + {{N{1'b0}}, 1'b1};
        step_ext  = {{(N + 1 - STEP_W){1'b0}}, step};
        step_eff  = (step_ext > range_ext) ? range_ext : step_ext;
        cnt_ext   = {1'b0, count_q};
        sum_up    = cnt_ext + step_eff;
        wrap_up   = sum_up - range_ext;
        diff_dn   = cnt_ext - step_eff;
        wrap_dn   = cnt_ext + range_ext - step_eff;
    end

    always_comb begin
        count_d = count_q;
        carry_d = 1'b0;
        if (load) begin
            count_d = (input_load > modulo_max) ? modulo_max : input_load;
        end else if (en) begin
            if (cnt_ext > max_ext) begin
                // Bound shrank below the current count: snap back and flag it.
                count_d = modulo_max;
                carry_d = 1'b1;
            end else if (step_eff == '0) begin
                count_d = count_q;
            end else if (up_down) begin
                if (sum_up <= max_ext) begin
                    count_d = sum_up[N-1:0];
                end else begin
                    count_d = sat_mode ? modulo_max : wrap_up[N-1:0];
                    carry_d = 1'b1;
                end
            end else begin
                if (step_eff <= cnt_ext) begin
                    count_d = diff_dn[N-1:0];
                end else begin
                    count_d = sat_mode ? '0 : wrap_dn[N-1:0];
                    carry_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            carry_q <= 1'b0;
        end else begin
            count_q <= count_d;
            carry_q <= carry_d;
        end
    end

    assign count_out = count_q;
    assign carry_out = carry_q;
    assign at_max    = (count_q == modulo_max);
    assign at_min    = (count_q == '0);

endmodule

// File: tb/tb_up_down_counter_mod.sv
// Directed bench for up_down_counter_mod at N=4 with hand-computed expectations.
module tb_up_down_counter_mod;

    localparam int N      = 4;
    localparam int STEP_W = 4;

    logic              clk;
    logic              rst;
    logic              en;
    logic              up_down;
    logic              load;
    logic [N-1:0]      input_load;
    logic [N-1:0]      modulo_max;
    logic [STEP_W-1:0] step;
    logic              sat_mode;
    logic [N-1:0]      count_out;
    logic              carry_out;
    logic              at_max;
    logic              at_min;

    int tests_run = 0;
    int tests_failed = 0;

    up_down_counter_mod #(.N(N), .STEP_W(STEP_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .up_down    (up_down),
        .load       (load),
        .input_load (input_load),
        .modulo_max (modulo_max),
        .step       (step),
        .sat_mode   (sat_mode),
        .count_out  (count_out),
        .carry_out  (carry_out),
        .at_max     (at_max),
        .at_min     (at_min)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_cc(input string tag, input int exp_cnt, input int exp_carry);
        chk({tag, ".count"}, 32'(count_out), 32'(exp_cnt));
        chk({tag, ".carry"}, 32'(carry_out), 32'(exp_carry));
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; up_down = 1'b1; load = 1'b0;
        input_load = '0; modulo_max = 4'd9; step = 4'd1; sat_mode = 1'b0;

        // Reset and hold
        for (int i = 0; i < 2; i++) begin
            tick();
            chk_cc("rst", 0, 0);
            chk("rst.at_min", 32'(at_min), 1);
            chk("rst.at_max", 32'(at_max), 0);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_cc("hold", 0, 0);
            chk("hold.at_min", 32'(at_min), 1);
        end

        // Up wrap, modulo 9, step 1
        load = 1'b1; input_load = 4'd7;
        tick(); chk_cc("upw.load", 7, 0);
        load = 1'b0; en = 1'b1; up_down = 1'b1;
        tick(); chk_cc("upw.8", 8, 0);
        tick(); chk_cc("upw.9", 9, 0); chk("upw.at_max", 32'(at_max), 1);
        tick(); chk_cc("upw.0", 0, 1); chk("upw.at_max0", 32'(at_max), 0);
        tick(); chk_cc("upw.1", 1, 0);

        // Down wrap, step 3
        en = 1'b0; load = 1'b1; input_load = 4'd2;
        tick(); chk_cc("dnw.load", 2, 0);
        load = 1'b0; en = 1'b1; up_down = 1'b0; step = 4'd3;
        tick(); chk_cc("dnw.9", 9, 1);
        tick(); chk_cc("dnw.6", 6, 0);
        tick(); chk_cc("dnw.3", 3, 0);

        // Saturate
        sat_mode = 1'b1; load = 1'b1; input_load = 4'd8;
        tick(); chk_cc("sat.load", 8, 0);
        load = 1'b0; up_down = 1'b1;
        tick(); chk_cc("sat.up1", 9, 1);
        tick(); chk_cc("sat.up2", 9, 1);
        tick(); chk_cc("sat.up3", 9, 1);
        load = 1'b1; input_load = 4'd1;
        tick(); chk_cc("sat.load1", 1, 0);
        load = 1'b0; up_down = 1'b0;
        tick(); chk_cc("sat.dn1", 0, 1);
        tick(); chk_cc("sat.dn2", 0, 1);

        // Load clamp and priority over en, then shrinking bound
        sat_mode = 1'b0; load = 1'b1; en = 1'b1; input_load = 4'd12;
        tick(); chk_cc("clamp", 9, 0);
        load = 1'b0; modulo_max = 4'd5; step = 4'd1; up_down = 1'b1;
        tick(); chk_cc("oor", 5, 1); chk("oor.at_max", 32'(at_max), 1);

        // Reset mid-count beats load
        modulo_max = 4'd9; load = 1'b1; input_load = 4'd6;
        tick(); chk_cc("mid.load", 6, 0);
        rst = 1'b1; load = 1'b1; input_load = 4'd3;
        tick(); chk_cc("mid.rst", 0, 0);
        rst = 1'b0; load = 1'b0;
        tick(); chk_cc("mid.resume", 1, 0);

        // modulo_max == 0: count pinned at 0, carry every enabled cycle
        modulo_max = 4'd0; step = 4'd2;
        tick(); chk_cc("m0.up", 0, 1);
        chk("m0.at_max", 32'(at_max), 1); chk("m0.at_min", 32'(at_min), 1);
        up_down = 1'b0;
        tick(); chk_cc("m0.dn", 0, 1);

        // Full-range bound: N+1-bit arithmetic
        modulo_max = 4'd15; load = 1'b1; input_load = 4'd14;
        tick(); chk_cc("full.load", 14, 0);
        load = 1'b0; up_down = 1'b1; step = 4'd15;
        tick(); chk_cc("full.up", 13, 1);
        up_down = 1'b0;
        tick(); chk_cc("full.dn", 14, 1);

        // Zero step holds; disabled cycle clears carry
        step = 4'd0;
        tick(); chk_cc("step0", 14, 0);
        step = 4'd1; up_down = 1'b1;
        tick(); chk_cc("full.15", 15, 0);
        tick(); chk_cc("full.wrap", 0, 1);
        en = 1'b0;
        tick(); chk_cc("hold.clr", 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/up_down_counter_mod.md
Name: up_down_counter_mod

Overview:
- Parametrised successor to the team's basic up/down counter.
- Adds:
  - programmable modulo bound
  - programmable step size
  - count enable
  - selectable wrap or saturate mode
  - registered terminal-event flag
  - at-limit status flags
- Used as a general event/address counter in datapath and control blocks where a plain 2^N rollover is insufficient.

Parameters:
- N, default 8: counter width in bits.
- STEP_W, default 4: width of step input; legal range 1..N.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- en  input  1  count enable.
- up_down  input  1  direction: 1 = up, 0 = down.
- load  input  1  synchronous parallel load request.
- input_load  input  N  value to load.
- modulo_max  input  N  upper bound; legal count range is 0..modulo_max.
- step  input  STEP_W  increment/decrement magnitude per enabled cycle.
- sat_mode  input  1  1 = saturate at bounds, 0 = wrap within 0..modulo_max.
- count_out  output  N  registered count value.
- carry_out  output  1  registered one-cycle pulse on overflow/underflow event.
- at_max  output  1  combinational: count_out == modulo_max.
- at_min  output  1  combinational: count_out == 0.

Behaviour:
- Reset values: rst=1 at a rising edge gives count_out=0 and carry_out=0. at_min=1; at_max=1 only if modulo_max==0.
- Priority per edge: rst > load > en > hold.
- Load (load=1):
  - count_out <= min(input_load, modulo_max); carry_out <= 0.
  - en is ignored on a load cycle.
- Hold (en=0, load=0): count_out unchanged; carry_out <= 0.
- Effective step:
  - step_eff = min(step, modulo_max+1), computed at N+1 bits.
  - step==0: count held, carry_out <= 0.
- Out-of-range state (count_out > modulo_max, possible after modulo_max changes), with en=1, load=0:
  - count_out <= modulo_max and carry_out <= 1.
  - Applies regardless of mode and direction.
- Up, in range:
  - s = count_out + step_eff, computed at N+1 bits.
  - If s <= modulo_max: count_out <= s, carry_out <= 0.
  - Otherwise, wrap mode: count_out <= s - (modulo_max+1), carry_out <= 1.
  - Otherwise, saturate mode: count_out <= modulo_max, carry_out <= 1.
- Down, in range:
  - If step_eff <= count_out: count_out <= count_out - step_eff, carry_out <= 0.
  - Otherwise, wrap mode: count_out <= count_out + (modulo_max+1) - step_eff, carry_out <= 1.
  - Otherwise, saturate mode: count_out <= 0, carry_out <= 1.
- Saturate mode at a bound: carry_out is 1 on every enabled cycle that attempts to move past the bound, so a sustained request gives a sustained carry.
- Latency: inputs sampled at edge k; count_out and carry_out valid after edge k. No combinational path from inputs to count_out or carry_out.
- modulo_max == 0: count stays 0. Every enabled nonzero-step cycle gives carry_out=1.
- modulo_max == 2^N-1: all intermediate arithmetic at N+1 bits, with no truncation error.
- Mid-operation changes: rst, mode, direction or modulo_max changes take effect at the next edge with no extra pipeline state.

Test Plan:
- Reset and hold:
  - Stimulus: rst=1 for 2 cycles; then rst=0, en=0 for 3 cycles.
  - Required: count_out=0, carry_out=0, at_min=1 throughout.
- Up wrap (N=4, modulo_max=9, step=1, sat_mode=0):
  - Stimulus: load 7, then en=1 up.
  - Required: count 8, 9, 0, 1. carry_out=1 only on the edge producing 0. at_max=1 while count=9.
- Down wrap with step (N=4, modulo_max=9, step=3, sat_mode=0):
  - Stimulus: load 2, count down.
  - Required: count 9 (carry 1), then 6, then 3 (carry 0).
- Saturate (N=4, modulo_max=9, step=3, sat_mode=1):
  - Stimulus: load 8, count up 3 cycles.
  - Required: count 9, 9, 9 with carry_out=1 each cycle.
  - Then down from 1 with step=3: count 0, carry 1.
- Load clamp and priority:
  - Stimulus: load=1, en=1, input_load=12, modulo_max=9.
  - Required: count_out=9, carry_out=0.
  - Then modulo_max=5 with en=1, step=1: count_out=5, carry_out=1.
- Reset mid-count:
  - Stimulus: counting up at 6; assert rst for one edge together with load=1, input_load=3.
  - Required: count_out=0, carry_out=0. Counting resumes from 0 after rst deasserts.
